load_unit: RTL and testbench

- Read-side counterpart of the core's data-memory store path.
- Accepts load requests (LB/LH/LW/LBU/LHU) from execute.
- Issues word reads to a synchronous-read, little-endian data memory with one-cycle read latency.
- Extracts and extends the addressed bytes, then hands the result and rd to write-back through a valid/ready handshake.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/load_align.sv | 36 +++
 rtl/load_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core definitions used by the load path.
//   XLEN             data/address width
//   F3_*             load funct3 encodings
//   load_state_e     load_unit FSM states
//   f3_is_legal()    true for the five supported load funct3 values
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        CAP,
        RESP
    } load_state_e;

    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational byte/halfword/word extraction for loads.
//   word1, word0  source words; {word1,word0} is the little-endian window
//   offset        byte offset of the access within word0
//   funct3        load type (LB/LH/LW sign-extend or take 32b, LBU/LHU zero-extend)
//   result        extended load value; '0 for an unsupported funct3
module load_align #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic [31:0]     word1,
    input  logic [31:0]     word0,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);
    import riscv_pkg::*;

    logic [63:0] window;
    logic        unused_window_hi;

    // Shift the 64-bit pair so the addressed byte lands at bit 0.
    assign window           = {word1, word0} >> {offset, 3'b000};
    assign unused_window_hi = ^window[63:32];

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){window[7]}}, window[7:0]};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, window[7:0]};
            F3_LH:   result = {{(XLEN-16){window[15]}}, window[15:0]};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, window[15:0]};
            F3_LW:   result = XLEN'(window[31:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: load path from execute to write-back via a synchronous-read,
// little-endian word memory with one-cycle read latency.
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i/req_ready_o       load request handshake
//   req_addr_i/funct3_i/rd_i      byte address, load type, destination reg
//   mem_rd_en_o/mem_rd_addr_o     word read strobe and word index
//   mem_rd_data_i                 read data, valid the cycle after the strobe
//   wb_valid_o/wb_ready_i         write-back handshake
//   wb_rd_o/wb_data_o/wb_err_o    result; held stable while wb_valid_o is high
// Build option MISALIGNED_SPLIT_EN: misaligned accesses are served (word-
// crossing ones as two reads via RD1) and only illegal funct3 errors. When
// undefined, every misaligned access errors without a memory read.
module load_unit #(
    parameter  int unsigned XLEN     = riscv_pkg::XLEN,
    parameter  int unsigned MEM_SIZE = 2048,
    localparam int unsigned AW       = $clog2(MEM_SIZE)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [4:0]      req_rd_i,
    output logic            mem_rd_en_o,
    output logic [AW-1:0]   mem_rd_addr_o,
    input  logic [31:0]     mem_rd_data_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            wb_err_o
);
    import riscv_pkg::*;

    load_state_e     state_q, state_d;

    logic [AW+1:0]   addr_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            err_q;
    logic [31:0]     word0_q;
    logic [XLEN-1:0] data_q;

    logic [AW-1:0]   idx0;
    logic [1:0]      req_off;
    logic            req_is_half;
    logic            req_is_word;
    logic            req_err;
    logic [31:0]     align_w1;
    logic [31:0]     align_w0;
    logic [XLEN-1:0] align_result;
    logic            unused_addr_hi;

    // Only the word index and byte offset of the address are ever needed.
    assign unused_addr_hi = ^req_addr_i[XLEN-1:AW+2];

    assign req_off     = req_addr_i[1:0];
    assign req_is_half = (req_funct3_i == F3_LH) || (req_funct3_i == F3_LHU);
    assign req_is_word = (req_funct3_i == F3_LW);
    assign idx0        = addr_q[AW+1:2];

`ifdef MISALIGNED_SPLIT_EN
    logic          split_q;
    logic          req_split;
    logic [31:0]   word1_q;
    logic [AW-1:0] idx1;

    // Only accesses that run past the end of word0 need a second read.
    assign req_err   = !f3_is_legal(req_funct3_i);
    assign req_split = !req_err &&
                       ((req_is_half && (req_off == 2'd3)) ||
                        (req_is_word && (req_off != 2'd0)));
    assign idx1      = (idx0 == AW'(MEM_SIZE - 1)) ? '0 : idx0 + AW'(1);

    // In CAP the memory returns word1 for a split access, word0 otherwise.
    assign align_w1  = split_q ? mem_rd_data_i : '0;
    assign align_w0  = split_q ? word0_q : mem_rd_data_i;
`else
    logic req_misal;

    assign req_misal = (req_is_half && req_off[0]) ||
                       (req_is_word && (req_off != 2'd0));
    assign req_err   = !f3_is_legal(req_funct3_i) || req_misal;
    assign align_w1  = '0;
    assign align_w0  = mem_rd_data_i;
`endif

    load_align #(
        .XLEN (XLEN)
    ) u_align (
        .word1  (align_w1),
        .word0  (align_w0),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .result (align_result)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            word0_q <= '0;
            data_q  <= '0;
`ifdef MISALIGNED_SPLIT_EN
            split_q <= 1'b0;
            word1_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i[AW+1:0];
                        f3_q    <= req_funct3_i;
                        rd_q    <= req_rd_i;
                        err_q   <= req_err;
                        data_q  <= '0;
`ifdef MISALIGNED_SPLIT_EN
                        split_q <= req_split;
`endif
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                RD1: word0_q <= mem_rd_data_i;
`endif
                CAP: begin
`ifdef MISALIGNED_SPLIT_EN
                    if (split_q) begin
                        word1_q <= mem_rd_data_i;
                    end else begin
                        word0_q <= mem_rd_data_i;
                    end
`else
                    word0_q <= mem_rd_data_i;
`endif
                    data_q <= align_result;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready_o   = 1'b0;
        mem_rd_en_o   = 1'b0;
        mem_rd_addr_o = '0;
        wb_valid_o    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = req_err ? RESP : RD0;
                end
            end
            RD0: begin
                mem_rd_en_o   = 1'b1;
                mem_rd_addr_o = idx0;
`ifdef MISALIGNED_SPLIT_EN
                state_d       = split_q ? RD1 : CAP;
`else
                state_d       = CAP;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            RD1: begin
                mem_rd_en_o   = 1'b1;
                mem_rd_addr_o = idx1;
                state_d       = CAP;
            end
`endif
            CAP: state_d = RESP;
            RESP: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_rd_o   = rd_q;
    assign wb_data_o = data_q;
    assign wb_err_o  = err_q;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed self-checking bench for load_unit with a
// one-cycle-latency word memory model. Latency is counted in clock edges
// after the acceptance edge.
module tb_load_unit;
    import riscv_pkg::*;

    localparam int unsigned MEM_SIZE = 2048;
    localparam int unsigned AW       = 11;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [2:0]    req_funct3;
    logic [4:0]    req_rd;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic          wb_valid;
    logic          wb_ready;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          wb_err;

    logic [31:0]   mem [MEM_SIZE];
    int unsigned   rd_log[$];
    int            passed;
    int            total;

    load_unit #(
        .MEM_SIZE (MEM_SIZE)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_funct3_i  (req_funct3),
        .req_rd_i      (req_rd),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_data_i (mem_rd_data),
        .wb_valid_o    (wb_valid),
        .wb_ready_i    (wb_ready),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
        .wb_err_o      (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    always @(posedge clk) begin
        if (mem_rd_en) rd_log.push_back(int'(mem_rd_addr));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one load with wb_ready low, check latency/result/reads, then handshake.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] exp_data, input logic exp_err,
                           input int exp_lat, input int exp_nrd,
                           input int unsigned exp_i0, input int unsigned exp_i1);
        int n;
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        rd_log.delete();
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        req_rd     = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!wb_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".lat"},  n, exp_lat);
        chk({tag, ".data"}, wb_data, exp_data);
        chk({tag, ".err"},  {31'd0, wb_err}, {31'd0, exp_err});
        chk({tag, ".rd"},   {27'd0, wb_rd}, {27'd0, rd});
        chk({tag, ".nrd"},  rd_log.size(), exp_nrd);
        if (exp_nrd > 0 && rd_log.size() > 0) chk({tag, ".idx0"}, rd_log[0], exp_i0);
        if (exp_nrd > 1 && rd_log.size() > 1) chk({tag, ".idx1"}, rd_log[1], exp_i1);
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        chk({tag, ".wb_drop"},  {31'd0, wb_valid}, 32'd0);
        chk({tag, ".ready_rt"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        logic seen;
        passed     = 0;
        total      = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        req_rd     = '0;
        wb_ready   = 1'b0;
        for (int unsigned i = 0; i < MEM_SIZE; i++) mem[i] = 32'h5A5A_0000 + i;
        mem[4]          = 32'h8899_AABB;
        mem[5]          = 32'h1122_3344;
        mem[MEM_SIZE-1] = 32'hDEAD_BEEF;
        mem[0]          = 32'h0123_4567;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.valid", {31'd0, wb_valid}, 32'd0);
        chk("rst.data",  wb_data, 32'd0);
        chk("rst.err",   {31'd0, wb_err}, 32'd0);
        chk("rst.rd",    {27'd0, wb_rd}, 32'd0);
        chk("rst.mem_en", {31'd0, mem_rd_en}, 32'd0);

        // Aligned word and extraction cases
        do_load("lw10",  F3_LW,  32'h10, 5'd1, 32'h8899_AABB, 1'b0, 2, 1, 4, 0);
        do_load("lb13",  F3_LB,  32'h13, 5'd2, 32'hFFFF_FF88, 1'b0, 2, 1, 4, 0);
        do_load("lbu13", F3_LBU, 32'h13, 5'd3, 32'h0000_0088, 1'b0, 2, 1, 4, 0);
        do_load("lh12",  F3_LH,  32'h12, 5'd4, 32'hFFFF_8899, 1'b0, 2, 1, 4, 0);
        do_load("lhu10", F3_LHU, 32'h10, 5'd5, 32'h0000_AABB, 1'b0, 2, 1, 4, 0);
        do_load("lb11",  F3_LB,  32'h11, 5'd6, 32'hFFFF_FFAA, 1'b0, 2, 1, 4, 0);
        do_load("lh16",  F3_LH,  32'h16, 5'd7, 32'h0000_1122, 1'b0, 2, 1, 5, 0);

        // Misaligned accesses
`ifdef MISALIGNED_SPLIT_EN
        do_load("lw12",   F3_LW,  32'h12,   5'd8,  32'h3344_8899, 1'b0, 3, 2, 4, 5);
        do_load("lh11",   F3_LH,  32'h11,   5'd9,  32'hFFFF_99AA, 1'b0, 2, 1, 4, 0);
        do_load("lhu13",  F3_LHU, 32'h13,   5'd10, 32'h0000_4488, 1'b0, 3, 2, 4, 5);
        do_load("lwwrap", F3_LW,  32'h1FFE, 5'd11, 32'h4567_DEAD, 1'b0, 3, 2, MEM_SIZE-1, 0);
`else
        do_load("lw12",   F3_LW,  32'h12,   5'd8,  32'h0, 1'b1, 0, 0, 0, 0);
        do_load("lh11",   F3_LH,  32'h11,   5'd9,  32'h0, 1'b1, 0, 0, 0, 0);
        do_load("lhu13",  F3_LHU, 32'h13,   5'd10, 32'h0, 1'b1, 0, 0, 0, 0);
        do_load("lwwrap", F3_LW,  32'h1FFE, 5'd11, 32'h0, 1'b1, 0, 0, 0, 0);
`endif

        // Illegal funct3 values
        do_load("f3_011", 3'b011, 32'h10, 5'd12, 32'h0, 1'b1, 0, 0, 0, 0);
        do_load("f3_110", 3'b110, 32'h10, 5'd13, 32'h0, 1'b1, 0, 0, 0, 0);
        do_load("f3_111", 3'b111, 32'h14, 5'd14, 32'h0, 1'b1, 0, 0, 0, 0);

        // Backpressure: hold RESP for 5 cycles, then a back-to-back request
        req_valid  = 1'b1;
        req_addr   = 32'h14;
        req_funct3 = F3_LW;
        req_rd     = 5'd15;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!wb_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp.lat", n, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.valid", {31'd0, wb_valid}, 32'd1);
            chk("bp.data",  wb_data, 32'h1122_3344);
            chk("bp.rd",    {27'd0, wb_rd}, 32'd15);
            chk("bp.err",   {31'd0, wb_err}, 32'd0);
            chk("bp.ready", {31'd0, req_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        do_load("b2b", F3_LBU, 32'h14, 5'd16, 32'h0000_0044, 1'b0, 2, 1, 5, 0);

        // Reset while in CAP drops the transaction
        req_valid  = 1'b1;
        req_addr   = 32'h10;
        req_funct3 = F3_LW;
        req_rd     = 5'd17;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid.rd0_en", {31'd0, mem_rd_en}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid.ready",   {31'd0, req_ready}, 32'd1);
        chk("mid.valid",   {31'd0, wb_valid}, 32'd0);
        chk("mid.data",    wb_data, 32'd0);
        chk("mid.err",     {31'd0, wb_err}, 32'd0);
        chk("mid.rd",      {27'd0, wb_rd}, 32'd0);
        chk("mid.mem_en",  {31'd0, mem_rd_en}, 32'd0);
        chk("mid.mem_adr", {21'd0, mem_rd_addr}, 32'd0);
        wb_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (wb_valid) seen = 1'b1;
        end
        wb_ready = 1'b0;
        chk("mid.no_wb", {31'd0, seen}, 32'd0);

        do_load("post", F3_LW, 32'h14, 5'd18, 32'h1122_3344, 1'b0, 2, 1, 5, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
